// File: rtl/fifo_flag_gen.sv
// Flag generator for one side of an asynchronous FIFO: it exports this side's Gray pointer,
// synchronizes the opposite side's Gray pointer and derives the empty/full, almost, level and error outputs.
module fifo_flag_gen #(
  parameter int DEEPWID = 3,
  parameter int MODE    = 0,
  parameter int ALMOST  = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DEEPWID:0]   local_addr,
  input  logic [DEEPWID:0]   remote_gray,
  output logic [DEEPWID:0]   local_gray,
  output logic               fe_flag,
  output logic               almost,
  output logic [DEEPWID:0]   level,
  output logic               err
);

  localparam int AW = DEEPWID + 1;
  localparam bit WRITE_SIDE = (MODE == 1);

  localparam logic [AW-1:0] DEPTH     = AW'(1) << DEEPWID;
  localparam logic [AW-1:0] FULL_THR  = AW'((2 ** DEEPWID) - ALMOST);
  localparam logic [AW-1:0] EMPTY_THR = AW'(ALMOST);
  // A full FIFO's pointers differ only in the top two Gray bits.
  localparam logic [AW-1:0] CMP_MASK  = WRITE_SIDE ? (AW'(3) << (DEEPWID - 1)) : '0;

  logic [AW-1:0] sync1;
  logic [AW-1:0] sync2;
  logic [AW-1:0] remote_bin;
  logic [AW-1:0] local_gray_now;
  logic [AW-1:0] level_ahead;

  function automatic logic [AW-1:0] bin2gray(input logic [AW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [AW-1:0] gray2bin(input logic [AW-1:0] g);
    logic [AW-1:0] b;
    for (int i = 0; i < AW; i++) begin
      b[i] = ^(g >> i);
    end
    return b;
  endfunction

  // Occupancy is always "write pointer minus read pointer", modulo 2^AW.
  function automatic logic [AW-1:0] occupancy(input logic [AW-1:0] loc,
                                              input logic [AW-1:0] rem);
    return WRITE_SIDE ? (loc - rem) : (rem - loc);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      local_gray <= '0;
    end else begin
      local_gray <= bin2gray(local_addr);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= remote_gray;
      sync2 <= sync1;
    end
  end

  assign remote_bin     = gray2bin(sync2);
  assign local_gray_now = bin2gray(local_addr);
  assign level          = occupancy(local_addr, remote_bin);

  assign fe_flag = (local_gray_now == (sync2 ^ CMP_MASK));
  assign almost  = WRITE_SIDE ? (level >= FULL_THR) : (level <= EMPTY_THR);

  // sync1 carries a single-bit Gray step, so it resolves to either the old or the new
  // pointer; looking at it lets err rise on the same edge an impossible level appears.
  assign level_ahead = occupancy(local_addr, gray2bin(sync1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else begin
      err <= err | (level > DEPTH) | (level_ahead > DEPTH);
    end
  end

endmodule

// File: tb/tb_fifo_flag_gen.sv
// Bench for fifo_flag_gen: a read-side (MODE 0) and a write-side (MODE 1) instance on one clock,
// directed scenarios plus a randomized FIFO traffic run against an occupancy-level reference model.
module tb_fifo_flag_gen;

  localparam int DW = 3;
  localparam int AW = DW + 1;
  localparam logic [AW-1:0] DEPTH = 4'd8;
  localparam logic [AW-1:0] ALM   = 4'd1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  // Pointers are driven as binary counts; remote sides see their Gray form.
  logic [AW-1:0] loc0 = '0, rem0 = '0, loc1 = '0, rem1 = '0;
  logic [AW-1:0] rg0, rg1;
  logic [AW-1:0] lg0, lv0, lg1, lv1;
  logic          fe0, al0, er0, fe1, al1, er1;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: remote pointer value visible to each side (binary), plus exported Gray and err.
  logic [AW-1:0] m_s1 [2];
  logic [AW-1:0] m_s2 [2];
  logic [AW-1:0] m_lg [2];
  logic          m_err [2];

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] to_gray(input logic [AW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  assign rg0 = to_gray(rem0);
  assign rg1 = to_gray(rem1);

  fifo_flag_gen #(.DEEPWID(DW), .MODE(0), .ALMOST(1)) dut_rd (
    .clk(clk), .rst_n(rst_n), .local_addr(loc0), .remote_gray(rg0),
    .local_gray(lg0), .fe_flag(fe0), .almost(al0), .level(lv0), .err(er0)
  );

  fifo_flag_gen #(.DEEPWID(DW), .MODE(1), .ALMOST(1)) dut_wr (
    .clk(clk), .rst_n(rst_n), .local_addr(loc1), .remote_gray(rg1),
    .local_gray(lg1), .fe_flag(fe1), .almost(al1), .level(lv1), .err(er1)
  );

  function automatic logic [AW-1:0] m_loc(input int d);
    return (d == 0) ? loc0 : loc1;
  endfunction

  function automatic logic [AW-1:0] m_level_of(input int d, input logic [AW-1:0] rb);
    return (d == 0) ? (rb - m_loc(0)) : (m_loc(1) - rb);
  endfunction

  function automatic logic [AW-1:0] m_level(input int d);
    return m_level_of(d, m_s2[d]);
  endfunction

  function automatic logic m_fe(input int d);
    return (d == 0) ? (m_level(0) == 4'd0) : (m_level(1) == DEPTH);
  endfunction

  function automatic logic m_almost(input int d);
    return (d == 0) ? (m_level(0) <= ALM) : (m_level(1) >= (DEPTH - ALM));
  endfunction

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      m_s1[d] = '0;
      m_s2[d] = '0;
      m_lg[d] = '0;
      m_err[d] = 1'b0;
    end
  endtask

  // One clock edge: advance the model with the inputs that were stable across it, then step off the edge.
  task automatic tick();
    logic [AW-1:0] pre;
    logic [AW-1:0] post;
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_s1[d] = '0;
        m_s2[d] = '0;
        m_lg[d] = '0;
        m_err[d] = 1'b0;
      end else begin
        pre = m_level(d);
        m_s2[d] = m_s1[d];
        m_s1[d] = (d == 0) ? rem0 : rem1;
        m_lg[d] = to_gray(m_loc(d));
        post = m_level(d);
        if (pre > DEPTH || post > DEPTH) m_err[d] = 1'b1;
      end
    end
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    loc0 = '0; rem0 = '0; loc1 = '0; rem1 = '0;
    model_clear();
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    tick();
    tick();
    n_cmp++; if (lg0 !== 4'd0) begin n_bad++; $display("FAIL reset_lgray: got %b want 0000", lg0); end
    n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", er0); end
    n_cmp++; if (fe0 !== 1'b1) begin n_bad++; $display("FAIL reset_fe_rd: got %b want 1", fe0); end
    n_cmp++; if (lv0 !== 4'd0) begin n_bad++; $display("FAIL reset_level_rd: got %0d want 0", lv0); end
    n_cmp++; if (al0 !== 1'b1) begin n_bad++; $display("FAIL reset_almost_rd: got %b want 1", al0); end
    n_cmp++; if (fe1 !== 1'b0) begin n_bad++; $display("FAIL reset_fe_wr: got %b want 0", fe1); end
    n_cmp++; if (al1 !== 1'b0) begin n_bad++; $display("FAIL reset_almost_wr: got %b want 0", al1); end
    #2 rst_n = 1'b1;
    // Build up non-zero state, then drop reset between edges.
    loc0 = 4'd5;
    tick();
    tick();
    n_cmp++; if (lg0 !== 4'b0111) begin n_bad++; $display("FAIL pre_reset_lgray: got %b want 0111", lg0); end
    n_cmp++; if (er0 !== m_err[0] || er0 !== 1'b1) begin n_bad++; $display("FAIL pre_reset_err: got %b want 1", er0); end
    #2;
    rst_n = 1'b0;
    loc0 = '0;
    model_clear();
    #1;
    n_cmp++; if (lg0 !== 4'd0) begin n_bad++; $display("FAIL async_reset_lgray: got %b want 0000", lg0); end
    n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL async_reset_err: got %b want 0", er0); end
    n_cmp++; if (fe0 !== 1'b1 || lv0 !== 4'd0) begin n_bad++; $display("FAIL async_reset_flags: got fe=%b lvl=%0d want fe=1 lvl=0", fe0, lv0); end
    tick();
    #2 rst_n = 1'b1;
  endtask

  task automatic test_sync_latency();
    apply_reset();
    rem0 = 4'd1;
    tick();
    n_cmp++; if (fe0 !== 1'b1) begin n_bad++; $display("FAIL latency_fe_edge1: got %b want 1", fe0); end
    n_cmp++; if (lv0 !== 4'd0) begin n_bad++; $display("FAIL latency_level_edge1: got %0d want 0", lv0); end
    tick();
    n_cmp++; if (fe0 !== 1'b0) begin n_bad++; $display("FAIL latency_fe_edge2: got %b want 0", fe0); end
    n_cmp++; if (lv0 !== 4'd1) begin n_bad++; $display("FAIL latency_level_edge2: got %0d want 1", lv0); end
    n_cmp++; if (al0 !== 1'b1) begin n_bad++; $display("FAIL latency_almost: got %b want 1", al0); end
    n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL latency_err: got %b want 0", er0); end
  endtask

  task automatic test_full();
    apply_reset();
    loc1 = 4'd8;
    #1;
    n_cmp++; if (fe1 !== 1'b1) begin n_bad++; $display("FAIL full_same_cycle: got %b want 1", fe1); end
    tick();
    tick();
    n_cmp++; if (lv1 !== 4'd8) begin n_bad++; $display("FAIL full_level: got %0d want 8", lv1); end
    n_cmp++; if (al1 !== 1'b1) begin n_bad++; $display("FAIL full_almost: got %b want 1", al1); end
    rem1 = 4'd1;
    tick();
    n_cmp++; if (fe1 !== 1'b1) begin n_bad++; $display("FAIL full_stale_hold: got %b want 1", fe1); end
    tick();
    n_cmp++; if (fe1 !== 1'b0) begin n_bad++; $display("FAIL full_release: got %b want 0", fe1); end
    n_cmp++; if (lv1 !== 4'd7) begin n_bad++; $display("FAIL full_level_after: got %0d want 7", lv1); end
    n_cmp++; if (al1 !== 1'b1) begin n_bad++; $display("FAIL full_almost_after: got %b want 1", al1); end
    n_cmp++; if (er1 !== 1'b0) begin n_bad++; $display("FAIL full_err: got %b want 0", er1); end
  endtask

  task automatic test_wrap();
    apply_reset();
    loc0 = 4'd15;
    rem0 = 4'd15;
    tick();
    tick();
    n_cmp++; if (fe0 !== 1'b1 || lv0 !== 4'd0) begin n_bad++; $display("FAIL wrap_empty: got fe=%b lvl=%0d want fe=1 lvl=0", fe0, lv0); end
    rem0 = 4'd0;
    tick();
    n_cmp++; if (fe0 !== 1'b1) begin n_bad++; $display("FAIL wrap_edge1: got %b want 1", fe0); end
    tick();
    n_cmp++; if (fe0 !== 1'b0) begin n_bad++; $display("FAIL wrap_fe: got %b want 0", fe0); end
    n_cmp++; if (lv0 !== 4'd1) begin n_bad++; $display("FAIL wrap_level: got %0d want 1", lv0); end
    n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL wrap_err: got %b want 0", er0); end
  endtask

  task automatic test_local_gray();
    apply_reset();
    rem0 = 4'd5;
    tick();
    tick();
    loc0 = 4'd5;
    #1;
    n_cmp++; if (lg0 !== 4'b0000) begin n_bad++; $display("FAIL lgray_before_edge: got %b want 0000", lg0); end
    n_cmp++; if (fe0 !== 1'b1) begin n_bad++; $display("FAIL lgray_fe_same_cycle: got %b want 1", fe0); end
    tick();
    n_cmp++; if (lg0 !== 4'b0111) begin n_bad++; $display("FAIL lgray_after_edge: got %b want 0111", lg0); end
    n_cmp++; if (lg0 !== m_lg[0]) begin n_bad++; $display("FAIL lgray_model: got %b want %b", lg0, m_lg[0]); end
  endtask

  task automatic test_err();
    apply_reset();
    rem0 = 4'd9;
    tick();
    n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL err_edge1: got %b want 0", er0); end
    tick();
    n_cmp++; if (er0 !== 1'b1) begin n_bad++; $display("FAIL err_edge2: got %b want 1", er0); end
    n_cmp++; if (lv0 !== 4'd9) begin n_bad++; $display("FAIL err_level: got %0d want 9", lv0); end
    rem0 = 4'd0;
    repeat (4) tick();
    n_cmp++; if (er0 !== 1'b1) begin n_bad++; $display("FAIL err_sticky: got %b want 1", er0); end
    n_cmp++; if (lv0 !== 4'd0) begin n_bad++; $display("FAIL err_level_back: got %0d want 0", lv0); end
    #1;
    rst_n = 1'b0;
    model_clear();
    #1;
    n_cmp++; if (er0 !== 1'b0) begin n_bad++; $display("FAIL err_cleared: got %b want 0", er0); end
    tick();
    #2 rst_n = 1'b1;
  endtask

  // Legal FIFO traffic: each side only moves its pointer based on the stale view it has of the other.
  task automatic test_random();
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [AW-1:0] occ;
    apply_reset();
    wptr = '0;
    rptr = '0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (((wptr - m_s2[1]) < DEPTH) && ($urandom_range(0, 99) < 60)) wptr = wptr + 4'd1;
      if (((m_s2[0] - rptr) != 4'd0) && ($urandom_range(0, 99) < 50)) rptr = rptr + 4'd1;
      loc0 = rptr; rem0 = wptr;
      loc1 = wptr; rem1 = rptr;
      #1;
      occ = wptr - rptr;
      for (int d = 0; d < 2; d++) begin
        n_cmp++;
        if (((d == 0) ? lv0 : lv1) !== m_level(d)) begin
          n_bad++; $display("FAIL rand_level dut%0d cyc%0d: got %0d want %0d", d, cyc, (d == 0) ? lv0 : lv1, m_level(d));
        end
        n_cmp++;
        if (((d == 0) ? fe0 : fe1) !== m_fe(d)) begin
          n_bad++; $display("FAIL rand_fe dut%0d cyc%0d: got %b want %b", d, cyc, (d == 0) ? fe0 : fe1, m_fe(d));
        end
        n_cmp++;
        if (((d == 0) ? al0 : al1) !== m_almost(d)) begin
          n_bad++; $display("FAIL rand_almost dut%0d cyc%0d: got %b want %b", d, cyc, (d == 0) ? al0 : al1, m_almost(d));
        end
        n_cmp++;
        if (((d == 0) ? lg0 : lg1) !== m_lg[d]) begin
          n_bad++; $display("FAIL rand_lgray dut%0d cyc%0d: got %b want %b", d, cyc, (d == 0) ? lg0 : lg1, m_lg[d]);
        end
        n_cmp++;
        if (((d == 0) ? er0 : er1) !== m_err[d]) begin
          n_bad++; $display("FAIL rand_err dut%0d cyc%0d: got %b want %b", d, cyc, (d == 0) ? er0 : er1, m_err[d]);
        end
      end
      n_cmp++;
      if (lv0 > occ || lv1 < occ) begin
        n_bad++; $display("FAIL rand_pessimism cyc%0d: rd=%0d wr=%0d true=%0d", cyc, lv0, lv1, occ);
      end
      tick();
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_sync_latency();
    test_full();
    test_wrap();
    test_local_gray();
    test_err();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_flag_gen.md
FIFO_FLAG_GEN -- requirements
Module: fifo_flag_gen

Parameters
REQ-001 SHALL have DEEPWID, default 3; log2 of FIFO depth (depth = 2^DEEPWID); pointers are DEEPWID+1 bits.
REQ-002 SHALL have MODE, default 0; 0 = read side (empty flag), 1 = write side (full flag).
REQ-003 SHALL have ALMOST, default 1; almost-threshold in entries, range 0..2^DEEPWID.

Interface
REQ-004 SHALL have clk  input  1  sole clock; all registers on posedge.
REQ-005 SHALL have rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have local_addr  input  DEEPWID+1  binary pointer of this side from the pointer/RAM-enable controller.
REQ-007 SHALL have remote_gray  input  DEEPWID+1  Gray pointer from the opposite clock domain, asynchronous to clk.
REQ-008 SHALL have local_gray  output  DEEPWID+1  registered Gray form of local_addr, for the opposite domain.
REQ-009 SHALL have fe_flag  output  1  full (MODE 1) or empty (MODE 0) flag to the pointer controller.
REQ-010 SHALL have almost  output  1  almost-full (MODE 1) or almost-empty (MODE 0).
REQ-011 SHALL have level  output  DEEPWID+1  occupancy as seen by this side.
REQ-012 SHALL have err  output  1  sticky pointer-inconsistency flag.

Function
REQ-013 SHALL register local_gray <= local_addr ^ (local_addr >> 1) every clk edge; latency 1 cycle.
REQ-014 SHALL pass remote_gray through a 2-flop synchronizer (sync1, sync2); no logic between flops; remote change visible at sync2 after 2 edges.
REQ-015 SHALL convert sync2 to binary remote_bin (bit i = XOR of sync2 bits DEEPWID..i).
REQ-016 SHALL compute level modulo 2^(DEEPWID+1): MODE 1 -> local_addr - remote_bin; MODE 0 -> remote_bin - local_addr.
REQ-017 SHALL derive fe_flag combinationally from local_addr and sync2 only (no combinational path from remote_gray); local_addr change reflected same cycle.
REQ-018 SHALL, MODE 0, assert fe_flag when gray(local_addr) == sync2.
REQ-019 SHALL, MODE 1, assert fe_flag when gray(local_addr) equals sync2 with its two MSBs inverted and remaining bits equal.
REQ-020 SHALL keep fe_flag consistent with level: MODE 0 fe_flag == (level==0); MODE 1 fe_flag == (level==2^DEEPWID).
REQ-021 SHALL assert almost: MODE 1 when level >= 2^DEEPWID - ALMOST; MODE 0 when level <= ALMOST.
REQ-022 SHALL handle pointer wrap (2^(DEEPWID+1)-1 -> 0) on either pointer with no flag glitch beyond the modular arithmetic above.
REQ-023 SHALL set err on the clk edge where level > 2^DEEPWID, and hold it until reset.
REQ-024 SHALL be pessimistic only: stale synchronized remote pointer may hold fe_flag asserted longer, never deassert it early.

Reset
REQ-025 SHALL, while rst_n low, immediately clear sync1, sync2, local_gray and err to 0 regardless of clk.
REQ-026 SHALL, with local_addr = 0 in reset, present level = 0, fe_flag = 1 (MODE 0) / 0 (MODE 1), almost = 1 (MODE 0, ALMOST >= 0) / 0 (MODE 1, ALMOST < 8).
REQ-027 SHALL, on reset assertion mid-operation, drop all synchronizer history; first release edge samples remote_gray afresh.

Verification (DEEPWID=3, ALMOST=1)
REQ-028 SHALL cover reset: rst_n=0 between edges -> local_gray=0, err=0 immediately; MODE 0 fe_flag=1, level=0.
REQ-029 SHALL cover MODE 0 sync latency: local_addr=0, remote_gray 0000->0001 held -> fe_flag=1 after 1st edge, 0 after 2nd; level=1, almost=1.
REQ-030 SHALL cover MODE 1 full: local_addr=1000, remote_gray=0000 -> fe_flag=1, level=8; remote_gray=0001 -> 2 edges later fe_flag=0, level=7, almost=1.
REQ-031 SHALL cover wrap: MODE 0, local_addr=1111, remote_gray=1000 (15) -> fe_flag=1; remote_gray=0000 (0) -> level=1, fe_flag=0 after 2 edges.
REQ-032 SHALL cover local_gray: local_addr=0101 -> local_gray=0111 after next edge.
REQ-033 SHALL cover err: MODE 0, local_addr=0, remote_gray=1101 (9) -> err=1 at 2nd edge, stays 1 after remote_gray=0 until rst_n=0.
